// File: rtl/wb_pkg.sv
// Shared definitions for the writeback queue slice.
//   DATA_W   : result width, matches the 8x32 register file
//   AW       : register address width
//   PHASE_W  : width of the one-hot CPU phase bus
//   PHASE_WB : phase bit that is the register write phase
//   wb_entry_t : one pending register write {wa, wd}
package wb_pkg;
    localparam int DATA_W   = 32;
    localparam int AW       = 3;
    localparam int PHASE_W  = 5;
    localparam int PHASE_WB = 4;

    typedef struct packed {
        logic [AW-1:0]     wa;
        logic [DATA_W-1:0] wd;
    } wb_entry_t;
endpackage

// File: rtl/writeback_queue_if.sv
// Bus bundle between the CPU datapath and the writeback queue.
// Groups phase/flush, the execute and load push handshakes, the register file
// write port, the bypass lookup and the occupancy count.
//   slave  : the queue side (writeback_queue)
//   master : the datapath side (producers, register file, operand read)
interface writeback_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [wb_pkg::PHASE_W-1:0] phase;
    logic                       flush;

    logic                       ex_valid;
    logic                       ex_ready;
    logic [wb_pkg::AW-1:0]      ex_wa;
    logic [wb_pkg::DATA_W-1:0]  ex_wd;

    logic                       mem_valid;
    logic                       mem_ready;
    logic [wb_pkg::AW-1:0]      mem_wa;
    logic [wb_pkg::DATA_W-1:0]  mem_wd;

    logic [wb_pkg::AW-1:0]      wa;
    logic [wb_pkg::DATA_W-1:0]  wd;
    logic                       we;

    logic [wb_pkg::AW-1:0]      q_ra1;
    logic [wb_pkg::AW-1:0]      q_ra2;
    logic                       byp_hit1;
    logic [wb_pkg::DATA_W-1:0]  byp_d1;
    logic                       byp_hit2;
    logic [wb_pkg::DATA_W-1:0]  byp_d2;

    logic [CNT_W-1:0]           count;

    modport slave (
        input  phase, flush,
        input  ex_valid, ex_wa, ex_wd,
        output ex_ready,
        input  mem_valid, mem_wa, mem_wd,
        output mem_ready,
        output wa, wd, we,
        input  q_ra1, q_ra2,
        output byp_hit1, byp_d1, byp_hit2, byp_d2,
        output count
    );

    modport master (
        output phase, flush,
        output ex_valid, ex_wa, ex_wd,
        input  ex_ready,
        output mem_valid, mem_wa, mem_wd,
        input  mem_ready,
        input  wa, wd, we,
        output q_ra1, q_ra2,
        input  byp_hit1, byp_d1, byp_hit2, byp_d2,
        input  count
    );
endinterface

// File: rtl/wb_fifo.sv
// In-order storage for pending register writes.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : synchronous clear, wins over push and pop
//   push, push_data : enqueue one entry (ignored when full)
//   pop        : retire the head entry (ignored when empty)
//   head       : oldest entry
//   full, empty, count : occupancy
//   rd_ptr     : head slot index, lets the caller walk entries oldest->youngest
//   entries    : raw storage slots
//   vld        : per-slot valid (slot currently holds a pending entry)
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        push,
    input  wb_entry_t                   push_data,
    input  logic                        pop,
    output wb_entry_t                   head,
    output logic                        full,
    output logic                        empty,
    output logic [CNT_W-1:0]            count,
    output logic [PTR_W-1:0]            rd_ptr,
    output wb_entry_t [DEPTH-1:0]       entries,
    output logic [DEPTH-1:0]            vld
);
    wb_entry_t [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Pointers are PTR_W wide with DEPTH a power of two, so increment wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload needs no reset: a slot is only observed while vld marks it.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_ptr_q] <= push_data;
    end

    // Slot i is pending when its distance from the head is below count.
    always_comb begin
        logic [PTR_W-1:0] age;
        age = '0;
        vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age    = PTR_W'(i) - rd_ptr_q;
            vld[i] = (CNT_W'(age) < count_q);
        end
    end

    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign rd_ptr  = rd_ptr_q;
    assign entries = mem_q;
endmodule

// File: rtl/writeback_queue.sv
// Writeback stage in front of the 8x32 register file.
// Accepts load (mem) and execute (ex) results, mem with fixed priority, queues
// them in order and offers the head entry to the register file; one entry
// retires on every write phase (phase[PHASE_WB]) edge.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset, discards all pending entries
//   bus  : writeback_queue_if.slave (phase, flush, ex/mem push handshakes,
//          wa/wd/we to the register file, bypass lookup, count)
// Build option: define WB_BYPASS_EN to build the pending-result bypass lookup;
// without it byp_hit1/2 and byp_d1/2 are tied to zero and q_ra1/2 are ignored.
module writeback_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    writeback_queue_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t             head;
    wb_entry_t             push_data;
    wb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      vld;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  full;
    logic                  empty;
    logic                  push_mem;
    logic                  push_ex;
    logic                  push;
    logic                  pop;

    // Ready depends only on registered occupancy: a full queue refuses a push
    // even on an edge where the head also retires.
    assign bus.mem_ready = !full && !bus.flush;
    assign bus.ex_ready  = !full && !bus.flush && !bus.mem_valid;

    assign push_mem  = bus.mem_valid && bus.mem_ready;
    assign push_ex   = bus.ex_valid && bus.ex_ready;
    assign push      = push_mem || push_ex;
    assign push_data = push_mem ? '{wa: bus.mem_wa, wd: bus.mem_wd}
                                : '{wa: bus.ex_wa,  wd: bus.ex_wd};

    assign pop = bus.phase[PHASE_WB] && !empty;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .rd_ptr    (rd_ptr),
        .entries   (entries),
        .vld       (vld)
    );

    // Head is masked while empty so the file port reads zero after reset.
    assign bus.we    = !empty;
    assign bus.wa    = empty ? '0 : head.wa;
    assign bus.wd    = empty ? '0 : head.wd;
    assign bus.count = count;

`ifdef WB_BYPASS_EN
    // Walk slots oldest to youngest so the last match is the youngest write.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx          = '0;
        bus.byp_hit1 = 1'b0;
        bus.byp_d1   = '0;
        bus.byp_hit2 = 1'b0;
        bus.byp_d2   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (vld[idx] && entries[idx].wa == bus.q_ra1) begin
                bus.byp_hit1 = 1'b1;
                bus.byp_d1   = entries[idx].wd;
            end
            if (vld[idx] && entries[idx].wa == bus.q_ra2) begin
                bus.byp_hit2 = 1'b1;
                bus.byp_d2   = entries[idx].wd;
            end
        end
    end
`else
    logic byp_unused;
    assign byp_unused   = &{1'b0, entries, vld, rd_ptr, bus.q_ra1, bus.q_ra2};
    assign bus.byp_hit1 = 1'b0;
    assign bus.byp_d1   = '0;
    assign bus.byp_hit2 = 1'b0;
    assign bus.byp_d2   = '0;
`endif
endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue with a retirement scoreboard.
// Stimulus pushes each accepted result onto exp_q; a monitor on the falling
// edge pops and compares whenever the queue presents a write in a write phase.
module tb_writeback_queue;
    import wb_pkg::*;

    localparam logic [4:0] P0 = 5'b00001;
    localparam logic [4:0] P4 = 5'b10000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    wb_entry_t exp_q[$];

    writeback_queue_if #(.DEPTH(4)) bus ();

    writeback_queue #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic [4:0] ph);
        bus.phase = ph;
        @(posedge clk);
        #1;
    endtask

    task automatic push_ex(input logic [2:0] a, input logic [31:0] d, input logic [4:0] ph);
        bus.ex_valid = 1'b1;
        bus.ex_wa    = a;
        bus.ex_wd    = d;
        exp_q.push_back('{wa: a, wd: d});
        tick(ph);
        bus.ex_valid = 1'b0;
    endtask

    // Retirement monitor: an entry retires on the next edge when we=1 in a write phase.
    initial begin
        wb_entry_t e;
        forever begin
            @(negedge clk);
            if (!rst && !bus.flush && bus.phase[PHASE_WB] && bus.we) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_write_we", 32'(bus.we), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("retire_wa", 32'(bus.wa), 32'(e.wa));
                    chk("retire_wd", bus.wd, e.wd);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        bus.phase = P0; bus.flush = 1'b0;
        bus.ex_valid = 1'b0; bus.ex_wa = '0; bus.ex_wd = '0;
        bus.mem_valid = 1'b0; bus.mem_wa = '0; bus.mem_wd = '0;
        bus.q_ra1 = '0; bus.q_ra2 = '0;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_we", 32'(bus.we), 32'd0);
        chk("rst_wa", 32'(bus.wa), 32'd0);
        chk("rst_wd", bus.wd, 32'd0);
        chk("rst_hit1", 32'(bus.byp_hit1), 32'd0);
        chk("rst_hit2", 32'(bus.byp_hit2), 32'd0);
        rst = 1'b0;
        tick(P0);

        // Single ex push, retires at next write phase
        push_ex(3'd2, 32'h11, P0);
        chk("t2_count1", 32'(bus.count), 32'd1);
        chk("t2_we", 32'(bus.we), 32'd1);
        tick(P4);
        chk("t2_count0", 32'(bus.count), 32'd0);

        // Push in a write phase while empty: must not retire that same edge
        push_ex(3'd4, 32'h44, P4);
        chk("lat_count", 32'(bus.count), 32'd1);
        tick(P4);
        chk("lat_count0", 32'(bus.count), 32'd0);

        // mem beats ex
        bus.ex_valid = 1'b1;  bus.ex_wa = 3'd1;  bus.ex_wd = 32'h21;
        bus.mem_valid = 1'b1; bus.mem_wa = 3'd3; bus.mem_wd = 32'h33;
        bus.phase = P0;
        #1;
        chk("t3_mem_ready", 32'(bus.mem_ready), 32'd1);
        chk("t3_ex_ready", 32'(bus.ex_ready), 32'd0);
        exp_q.push_back('{wa: 3'd3, wd: 32'h33});
        tick(P0);
        bus.mem_valid = 1'b0;
        exp_q.push_back('{wa: 3'd1, wd: 32'h21});
        tick(P0);
        bus.ex_valid = 1'b0;
        chk("t3_count2", 32'(bus.count), 32'd2);
        tick(P4);
        tick(P4);
        chk("t3_count0", 32'(bus.count), 32'd0);

        // Fill, no push-through when full, push+pop, wrap
        for (int i = 0; i < 4; i++) push_ex(3'(i), 32'h40 + 32'(i), P0);
        chk("t4_count4", 32'(bus.count), 32'd4);
        chk("t4_ex_ready", 32'(bus.ex_ready), 32'd0);
        chk("t4_mem_ready", 32'(bus.mem_ready), 32'd0);
        bus.ex_valid = 1'b1; bus.ex_wa = 3'd7; bus.ex_wd = 32'hDEAD;
        tick(P4);
        bus.ex_valid = 1'b0;
        chk("t4_full_pop_count", 32'(bus.count), 32'd3);
        for (int i = 0; i < 7; i++) begin
            push_ex(3'((i + 5) & 7), 32'h50 + 32'(i), P4);
            chk("t4_pushpop_count", 32'(bus.count), 32'd3);
        end
        for (int i = 0; i < 3; i++) tick(P4);
        chk("t4_drained", 32'(bus.count), 32'd0);

        // Bypass: youngest pending wins, incoming push not visible
        push_ex(3'd5, 32'hA, P0);
        push_ex(3'd2, 32'h22, P0);
        push_ex(3'd5, 32'hB, P0);
        bus.q_ra1 = 3'd5; bus.q_ra2 = 3'd6;
        bus.ex_valid = 1'b1; bus.ex_wa = 3'd6; bus.ex_wd = 32'h66;
        #1;
`ifdef WB_BYPASS_EN
        chk("t5_hit1", 32'(bus.byp_hit1), 32'd1);
        chk("t5_d1", bus.byp_d1, 32'hB);
        chk("t5_hit2", 32'(bus.byp_hit2), 32'd0);
        bus.q_ra2 = 3'd2;
        #1;
        chk("t5_hit2b", 32'(bus.byp_hit2), 32'd1);
        chk("t5_d2b", bus.byp_d2, 32'h22);
`else
        chk("t5_hit1_off", 32'(bus.byp_hit1), 32'd0);
        chk("t5_d1_off", bus.byp_d1, 32'd0);
        chk("t5_hit2_off", 32'(bus.byp_hit2), 32'd0);
`endif
        bus.ex_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick(P4);
        chk("t5_drained", 32'(bus.count), 32'd0);

        // Flush during a write phase: no retire, no push
        push_ex(3'd6, 32'h61, P0);
        push_ex(3'd7, 32'h71, P0);
        chk("t6_count2", 32'(bus.count), 32'd2);
        bus.flush = 1'b1;
        bus.ex_valid = 1'b1; bus.ex_wa = 3'd1; bus.ex_wd = 32'h99;
        bus.phase = P4;
        #1;
        chk("t6_ex_ready", 32'(bus.ex_ready), 32'd0);
        tick(P4);
        bus.flush = 1'b0;
        bus.ex_valid = 1'b0;
        exp_q.delete();
        chk("t6_count0", 32'(bus.count), 32'd0);
        chk("t6_we", 32'(bus.we), 32'd0);
        tick(P4);

        // Reset mid-stream with three pending
        push_ex(3'd1, 32'h101, P0);
        push_ex(3'd2, 32'h102, P0);
        push_ex(3'd3, 32'h103, P0);
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("t1_count0", 32'(bus.count), 32'd0);
        chk("t1_we", 32'(bus.we), 32'd0);
        tick(P4);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick(P4);
        chk("t1_after_count", 32'(bus.count), 32'd0);
        chk("t1_after_we", 32'(bus.we), 32'd0);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
